// File: rtl/char_ring_mem.sv
// Character ring memory: a DEPTH-word circulating shift ring, with its output at
// position DEPTH-1 and its input at position 0. Each shift either recirculates
// the outgoing word or replaces it with din, so every word keeps a stable
// logical address (head_addr). A clear sequence fills the whole ring with FILL
// over exactly DEPTH cycles.
module char_ring_mem #(
    parameter int unsigned     WIDTH = 6,
    parameter int unsigned     DEPTH = 1024,
    parameter logic [WIDTH-1:0] FILL = WIDTH'(6'h20)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     shift_en,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     clr_req,
    input  logic [$clog2(DEPTH)-1:0] cursor_addr,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH)-1:0] head_addr,
    output logic                     at_cursor,
    output logic                     busy,
    output logic                     wrap
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   cnt_next;
    logic            shift_c;
    logic [WIDTH-1:0] in_word_c;
    logic [AW-1:0]   head_inc_c;

    logic [WIDTH-1:0] ring [DEPTH];

    // Output word is whatever sits at the exit position of the ring.
    assign dout = ring[DEPTH-1];

    // head_addr never exceeds DEPTH-1, so an out-of-range cursor cannot match.
    assign at_cursor = (cursor_addr == head_addr);

    // Modulo-DEPTH increment; explicit wrap keeps non-power-of-2 depths correct.
    assign head_inc_c = (head_addr == LAST) ? '0 : head_addr + AW'(1);

    // Next-state, shift enable and entering-word selection.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        shift_c    = 1'b0;
        in_word_c  = dout;
        case (state)
            IDLE: begin
                shift_c = shift_en;
                if (wr_en) begin
                    in_word_c = din;
                end
                if (clr_req) begin
                    next_state = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                shift_c   = 1'b1;
                in_word_c = FILL;
                if (cnt == LAST) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + AW'(1);
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        // Reset takes priority over any shift in the same cycle.
        if (reset) begin
            shift_c = 1'b0;
        end
    end

    // Control state, head address, busy flag and wrap pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            head_addr <= '0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            busy  <= (next_state == CLEAR);
            wrap  <= shift_c && (head_addr == LAST);
            if (shift_c) begin
                head_addr <= head_inc_c;
            end
        end
    end

    // Ring storage; deliberately not reset so contents survive an aborted clear.
    always_ff @(posedge clk) begin
        if (shift_c) begin
            ring[0] <= in_word_c;
            for (int i = 1; i < int'(DEPTH); i++) begin
                ring[i] <= ring[i-1];
            end
        end
    end

endmodule

// File: tb/tb_char_ring_mem.sv
// Directed bench for char_ring_mem: DEPTH=8 instance for clear/write/abort
// behaviour, DEPTH=6 instance for non-power-of-2 wrap and cursor matching.
module tb_char_ring_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DEPTH=8 instance signals
    logic       a_reset, a_shift, a_wr, a_clr;
    logic [5:0] a_din;
    logic [2:0] a_cursor;
    logic [5:0] a_dout;
    logic [2:0] a_head;
    logic       a_at, a_busy, a_wrap;

    // DEPTH=6 instance signals
    logic       b_reset, b_shift, b_wr, b_clr;
    logic [5:0] b_din;
    logic [2:0] b_cursor;
    logic [5:0] b_dout;
    logic [2:0] b_head;
    logic       b_at, b_busy, b_wrap;

    char_ring_mem #(.WIDTH(6), .DEPTH(8), .FILL(6'h20)) dut_a (
        .clk(clk), .reset(a_reset), .shift_en(a_shift), .wr_en(a_wr), .din(a_din),
        .clr_req(a_clr), .cursor_addr(a_cursor), .dout(a_dout), .head_addr(a_head),
        .at_cursor(a_at), .busy(a_busy), .wrap(a_wrap)
    );

    char_ring_mem #(.WIDTH(6), .DEPTH(6), .FILL(6'h20)) dut_b (
        .clk(clk), .reset(b_reset), .shift_en(b_shift), .wr_en(b_wr), .din(b_din),
        .clr_req(b_clr), .cursor_addr(b_cursor), .dout(b_dout), .head_addr(b_head),
        .at_cursor(b_at), .busy(b_busy), .wrap(b_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int cnt;
    int eh;
    logic wexp;

    initial begin
        a_reset = 1'b1; a_shift = 1'b0; a_wr = 1'b0; a_clr = 1'b0; a_din = '0; a_cursor = 3'd3;
        b_reset = 1'b1; b_shift = 1'b0; b_wr = 1'b0; b_clr = 1'b0; b_din = '0; b_cursor = 3'd5;
        step();
        chk("rst_head", 32'(a_head), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_wrap", 32'(a_wrap), 0);
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Clear: busy for exactly 8 cycles, head ends where it started.
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        cnt = 0;
        while (a_busy === 1'b1 && cnt < 20) begin
            cnt++;
            step();
        end
        chk("clr_busy_len", 32'(cnt), 8);
        chk("clr_head_end", 32'(a_head), 0);
        chk("clr_last_wrap", 32'(a_wrap), 1);
        a_shift = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("clr_dout", 32'(a_dout), 'h20);
            chk("clr_head", 32'(a_head), 32'(i));
            step();
        end

        // Write 0x01..0x08 at heads 0..7, then read one revolution back.
        a_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_din = 6'(i + 1);
            step();
        end
        a_wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("rd_dout", 32'(a_dout), 32'(i + 1));
            chk("rd_head", 32'(a_head), 32'(i));
            step();
            chk("rd_wrap", 32'(a_wrap), 32'(i == 7));
        end

        // wr_en without shift: no change, and nothing written.
        a_shift = 1'b0;
        a_wr    = 1'b1;
        a_din   = 6'h3F;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_dout", 32'(a_dout), 'h01);
            chk("hold_head", 32'(a_head), 0);
        end
        a_wr    = 1'b0;
        a_shift = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("nowr_dout", 32'(a_dout), 32'(i + 1));
            step();
        end
        a_shift = 1'b0;

        // clr_req and wr_en held through the whole clear: ignored.
        a_clr = 1'b1;
        a_wr  = 1'b1;
        a_din = 6'h11;
        step();
        cnt = 0;
        while (a_busy === 1'b1 && cnt < 20) begin
            cnt++;
            step();
        end
        a_clr = 1'b0;
        a_wr  = 1'b0;
        chk("hold_clr_len", 32'(cnt), 8);
        chk("hold_clr_head", 32'(a_head), 0);
        a_shift = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("hold_clr_dout", 32'(a_dout), 'h20);
            step();
        end

        // Aborted clear: rewrite ring, clear three words, then reset.
        a_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_din = 6'(i + 1);
            step();
        end
        a_wr    = 1'b0;
        a_shift = 1'b0;
        a_clr   = 1'b1;
        step();
        a_clr = 1'b0;
        step();
        step();
        step();
        chk("abort_pre_busy", 32'(a_busy), 1);
        chk("abort_pre_head", 32'(a_head), 3);
        a_reset = 1'b1;
        step();
        a_reset = 1'b0;
        chk("abort_busy", 32'(a_busy), 0);
        chk("abort_head", 32'(a_head), 0);
        // Words originally at addresses 3..7 survive; 0..2 were filled.
        a_shift = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("abort_dout", 32'(a_dout), (i < 5) ? 32'(i + 4) : 'h20);
            chk("abort_head_rev", 32'(a_head), 32'(i));
            step();
        end
        a_shift = 1'b0;
        chk("abort_no_busy", 32'(a_busy), 0);

        // DEPTH=6: head wraps 5->0, cursor 5 matches once per revolution.
        b_shift = 1'b1;
        eh = 0;
        for (int i = 0; i < 12; i++) begin
            chk("b_head", 32'(b_head), 32'(eh));
            chk("b_at5", 32'(b_at), 32'(eh == 5));
            wexp = (eh == 5);
            step();
            eh = (eh == 5) ? 0 : eh + 1;
            chk("b_wrap", 32'(b_wrap), 32'(wexp));
        end
        b_cursor = 3'd7;
        for (int i = 0; i < 6; i++) begin
            chk("b_at7", 32'(b_at), 0);
            step();
        end
        b_shift = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
